// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Word-addressed main memory sitting below the cache. Accepts one request
//   at a time over a valid/ready handshake, stalls for LATENCY cycles in BUSY,
//   commits the operation and then issues a single-cycle response pulse.
//   Request types: 128-bit block read, 128-bit block write, 32-bit word write.
//
// Parameters
//   LATENCY : cycles spent in BUSY before the response (1..15)
//   ADDR_W  : byte address width; storage is 2^(ADDR_W-2) 32-bit words
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (also reloads mem[i] = i)
//   req_valid  : request present
//   req_ready  : high only in IDLE
//   req_write  : 1 = write, 0 = block read
//   req_block  : on writes, 1 = block write, 0 = word write
//   req_addr   : byte address
//   req_wdata  : write data (word writes use [31:0])
//   resp_valid : one-cycle pulse when a request completes
//   resp_rdata : last committed block read data
//
// Optional build macro
//   MEM_STATS_EN : adds saturating 16-bit counters stat_reads,
//                  stat_block_writes and stat_word_writes.

module main_memory_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_block,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              resp_valid,
  output logic [127:0]      resp_rdata
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_block_writes,
  output logic [15:0]       stat_word_writes
`endif
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam int WORDS  = 1 << WIDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef logic [31:0] mem_t [WORDS];

  // Deterministic power-on contents: each word holds its own index.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < WORDS; i++) begin
      m[i] = 32'(i);
    end
    return m;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              block_q, block_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [127:0]      wdata_q, wdata_d;
  logic [127:0]      rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  mem_t              mem_q, mem_d;

  logic              commit_s;
  logic              commit_rd_s;
  logic              commit_blk_s;
  logic              commit_word_s;
  logic [WIDX_W-1:0] b0_s, b1_s, b2_s, b3_s;

  // Byte-offset bits never select anything.
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr[1:0];

  // Block word indices: the latched word index with its low two bits forced.
  assign b0_s = {widx_q[WIDX_W-1:2], 2'd0};
  assign b1_s = {widx_q[WIDX_W-1:2], 2'd1};
  assign b2_s = {widx_q[WIDX_W-1:2], 2'd2};
  assign b3_s = {widx_q[WIDX_W-1:2], 2'd3};

  // Request FSM: latch in IDLE, count down in BUSY, pulse in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    block_d  = block_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          block_d = req_block;
          widx_d  = req_addr[ADDR_W-1:2];
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          commit_s = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign commit_rd_s   = commit_s & ~write_q;
  assign commit_blk_s  = commit_s & write_q & block_q;
  assign commit_word_s = commit_s & write_q & ~block_q;

  // Next-cycle outputs derived from the next state so they come straight off flops.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    if (commit_rd_s) begin
      rdata_d = {mem_q[b0_s], mem_q[b1_s], mem_q[b2_s], mem_q[b3_s]};
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage update at commit; lowest address lands in the top 32 bits.
  always_comb begin
    mem_d = mem_q;
    if (commit_blk_s) begin
      mem_d[b0_s] = wdata_q[127:96];
      mem_d[b1_s] = wdata_q[95:64];
      mem_d[b2_s] = wdata_q[63:32];
      mem_d[b3_s] = wdata_q[31:0];
    end else if (commit_word_s) begin
      mem_d[widx_q] = wdata_q[31:0];
    end else begin
      mem_d = mem_q;
    end
  end

  // State, request latches, outputs and storage; reset aborts any pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      block_q <= 1'b0;
      widx_q  <= '0;
      wdata_q <= 128'd0;
      rdata_q <= 128'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      mem_q   <= mem_init();
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      block_q <= block_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;

`ifdef MEM_STATS_EN
  logic [15:0] stat_reads_q, stat_reads_d;
  logic [15:0] stat_bw_q, stat_bw_d;
  logic [15:0] stat_ww_q, stat_ww_d;

  // Saturating completion counters, bumped in the commit cycle.
  always_comb begin
    if (commit_rd_s && (stat_reads_q != 16'hFFFF)) begin
      stat_reads_d = stat_reads_q + 16'd1;
    end else begin
      stat_reads_d = stat_reads_q;
    end
    if (commit_blk_s && (stat_bw_q != 16'hFFFF)) begin
      stat_bw_d = stat_bw_q + 16'd1;
    end else begin
      stat_bw_d = stat_bw_q;
    end
    if (commit_word_s && (stat_ww_q != 16'hFFFF)) begin
      stat_ww_d = stat_ww_q + 16'd1;
    end else begin
      stat_ww_d = stat_ww_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q <= 16'd0;
      stat_bw_q    <= 16'd0;
      stat_ww_q    <= 16'd0;
    end else begin
      stat_reads_q <= stat_reads_d;
      stat_bw_q    <= stat_bw_d;
      stat_ww_q    <= stat_ww_d;
    end
  end

  assign stat_reads        = stat_reads_q;
  assign stat_block_writes = stat_bw_q;
  assign stat_word_writes  = stat_ww_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder
//   Directed bench for main_memory_responder (LATENCY=4, ADDR_W=10).
//   Every expected value is hand-computed from the reset image mem[i] = i.

module tb_main_memory_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_block;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic [127:0] resp_rdata;
`ifdef MEM_STATS_EN
  logic [15:0]  stat_reads;
  logic [15:0]  stat_block_writes;
  logic [15:0]  stat_word_writes;
`endif

  int n_cmp;
  int n_err;

  main_memory_responder #(.LATENCY(LAT), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_block  (req_block),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
`ifdef MEM_STATS_EN
    ,
    .stat_reads        (stat_reads),
    .stat_block_writes (stat_block_writes),
    .stat_word_writes  (stat_word_writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, watch a fixed window and check timing.
  task automatic do_req(input logic w, input logic b, input logic [9:0] a,
                        input logic [127:0] wd, input string tag,
                        output logic [127:0] rd);
    int low_n;
    int pulse_n;
    int pos;
    check({tag, "_ready"}, {127'd0, req_ready}, 128'd1);
    req_valid = 1'b1;
    req_write = w;
    req_block = b;
    req_addr  = a;
    req_wdata = wd;
    step();
    // Inputs are don't-care after acceptance; scramble them.
    req_valid = 1'b0;
    req_write = ~w;
    req_block = ~b;
    req_addr  = ~a;
    req_wdata = ~wd;
    low_n   = 0;
    pulse_n = 0;
    pos     = 0;
    rd      = 128'd0;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (!req_ready) low_n++;
      if (resp_valid) begin
        pulse_n++;
        pos = k;
        rd  = resp_rdata;
      end
      step();
    end
    check({tag, "_lat"}, 128'(pos), 128'(LAT + 1));
    check({tag, "_pulses"}, 128'(pulse_n), 128'd1);
    check({tag, "_busy"}, 128'(low_n), 128'(LAT + 1));
  endtask

  initial begin
    logic [127:0] rd;
    int acc [3];
    int acc_n;
    int pulse_n;

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_block = 1'b0;
    req_addr  = 10'h000;
    req_wdata = 128'd0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_ready", {127'd0, req_ready}, 128'd1);
    check("rst_valid", {127'd0, resp_valid}, 128'd0);
    check("rst_rdata", resp_rdata, 128'd0);

    // Block read at 0x050: words 0x14..0x17 (req_block/wdata ignored)
    do_req(1'b0, 1'b0, 10'h050, {4{32'h5555_AAAA}}, "rd050", rd);
    check("rd050_data", rd, {32'h14, 32'h15, 32'h16, 32'h17});

    // Word write to 0x058 -> word 0x16; rdata holds across writes
    do_req(1'b1, 1'b0, 10'h058, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF}, "ww058", rd);
    check("ww058_hold", resp_rdata, {32'h14, 32'h15, 32'h16, 32'h17});
    do_req(1'b0, 1'b0, 10'h050, 128'd0, "rd050b", rd);
    check("rd050b_data", rd, {32'h14, 32'h15, 32'hDEAD_BEEF, 32'h17});

    // Block write at 0x3F0, read back via 0x3FC (offset bits ignored)
    do_req(1'b1, 1'b1, 10'h3F0, {32'hA, 32'hB, 32'hC, 32'hD}, "bw3f0", rd);
    check("bw3f0_hold", resp_rdata, {32'h14, 32'h15, 32'hDEAD_BEEF, 32'h17});
    do_req(1'b0, 1'b1, 10'h3FC, 128'd0, "rd3fc", rd);
    check("rd3fc_data", rd, {32'hA, 32'hB, 32'hC, 32'hD});

    // Word write into the last block (word 254), then read it back
    do_req(1'b1, 1'b0, 10'h3FA, {96'd0, 32'h1234_5678}, "ww3fa", rd);
    do_req(1'b0, 1'b0, 10'h3F0, 128'd0, "rd3f0", rd);
    check("rd3f0_data", rd, {32'hA, 32'hB, 32'h1234_5678, 32'hD});

    // req_valid held high: three reads of 0x000 back to back
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block = 1'b0;
    req_addr  = 10'h000;
    acc_n     = 0;
    pulse_n   = 0;
    for (int c = 0; c < 24; c++) begin
      if (req_valid && req_ready && acc_n < 3) begin
        acc[acc_n] = c;
        acc_n++;
      end
      if (resp_valid) pulse_n++;
      step();
      if (acc_n == 3) req_valid = 1'b0;
    end
    check("b2b_acc_n", 128'(acc_n), 128'd3);
    check("b2b_gap1", 128'(acc[1] - acc[0]), 128'(LAT + 2));
    check("b2b_gap2", 128'(acc[2] - acc[1]), 128'(LAT + 2));
    check("b2b_pulses", 128'(pulse_n), 128'd3);
    check("b2b_data", resp_rdata, {32'h0, 32'h1, 32'h2, 32'h3});

    // Reset during the second BUSY cycle of a block write to 0x000
    req_valid = 1'b1;
    req_write = 1'b1;
    req_block = 1'b1;
    req_addr  = 10'h000;
    req_wdata = {4{32'hFFFF_FFFF}};
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", {127'd0, req_ready}, 128'd1);
    check("abort_rdata", resp_rdata, 128'd0);
    pulse_n = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (resp_valid) pulse_n++;
      step();
    end
    check("abort_pulses", 128'(pulse_n), 128'd0);
    do_req(1'b0, 1'b0, 10'h000, 128'd0, "rd000", rd);
    check("rd000_data", rd, {32'h0, 32'h1, 32'h2, 32'h3});

`ifdef MEM_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stat_rst_rd", {112'd0, stat_reads}, 128'd0);
    check("stat_rst_bw", {112'd0, stat_block_writes}, 128'd0);
    check("stat_rst_ww", {112'd0, stat_word_writes}, 128'd0);
    do_req(1'b0, 1'b0, 10'h010, 128'd0, "st_rd1", rd);
    do_req(1'b0, 1'b1, 10'h020, 128'd0, "st_rd2", rd);
    do_req(1'b1, 1'b1, 10'h030, {4{32'h0F0F_0F0F}}, "st_bw", rd);
    do_req(1'b1, 1'b0, 10'h040, 128'd7, "st_ww1", rd);
    do_req(1'b1, 1'b0, 10'h044, 128'd8, "st_ww2", rd);
    do_req(1'b1, 1'b0, 10'h048, 128'd9, "st_ww3", rd);
    check("stat_rd", {112'd0, stat_reads}, 128'd2);
    check("stat_bw", {112'd0, stat_block_writes}, 128'd1);
    check("stat_ww", {112'd0, stat_word_writes}, 128'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stat_clr_rd", {112'd0, stat_reads}, 128'd0);
    check("stat_clr_bw", {112'd0, stat_block_writes}, 128'd0);
    check("stat_clr_ww", {112'd0, stat_word_writes}, 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
